// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Turns a stream of UART bytes into framed commands. A frame is
//    0x55, 0xAA, CMD, LEN, LEN payload bytes, CSUM
// where CSUM is the 8-bit sum of CMD, LEN and every payload byte. Payload
// bytes are packed in pairs into 16-bit words (first byte in the high half)
// and handed downstream before the checksum arrives, so downstream must drop
// the frame's words when frame_err_o pulses. A frame that stalls between
// bytes for longer than the timeout is aborted.
//
// Ports
//    clk_i            clock, rising edge
//    rst_ni           asynchronous active-low reset
//    rx_data_i        byte from the UART receiver
//    rx_data_valid_i  rx_data_i holds a byte
//    rx_data_ready_o  parser takes the byte this cycle
//    wr_data_o        assembled payload word
//    wr_valid_o       wr_data_o is valid
//    wr_ready_i       downstream takes the word
//    wr_last_o        word holds the final payload byte of the frame
//    cmd_o            command byte of the current/last frame
//    frame_done_o     one-cycle pulse, frame complete with good checksum
//    frame_err_o      one-cycle pulse, frame aborted
//    err_code_o       01 checksum mismatch, 10 timeout
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int CLK_FRE    = 50,
   parameter int TIMEOUT_US = 10000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_data_valid_i,
   output logic        rx_data_ready_o,
   output logic [15:0] wr_data_o,
   output logic        wr_valid_o,
   input  logic        wr_ready_i,
   output logic        wr_last_o,
   output logic [7:0]  cmd_o,
   output logic        frame_done_o,
   output logic        frame_err_o,
   output logic [1:0]  err_code_o
);

   localparam int TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_WORD,
      S_CSUM
   } state_t;

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic             wr_last_q, wr_last_d;
   logic [7:0]       cmd_q, cmd_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [7:0]       accum_q, accum_d;
   logic [7:0]       remain_q, remain_d;
   logic             odd_q, odd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             timeout;

   // All state lives here; every register returns to zero on reset, which
   // also drops any half-built frame or pending word without an error pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_HDR0;
         ready_q    <= 1'b0;
         wr_data_q  <= '0;
         wr_last_q  <= 1'b0;
         cmd_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         accum_q    <= '0;
         remain_q   <= '0;
         odd_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         wr_data_q  <= wr_data_d;
         wr_last_q  <= wr_last_d;
         cmd_q      <= cmd_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         accum_q    <= accum_d;
         remain_q   <= remain_d;
         odd_q      <= odd_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic. remain_q counts payload bytes still to arrive and
   // odd_q says the next payload byte fills the low half of the word. The
   // inter-byte timer is idle in S_HDR0 (nothing to abort) and frozen in
   // S_WORD (backpressure from downstream is not the sender's fault).
   always_comb begin
      state_d    = state_q;
      wr_data_d  = wr_data_q;
      wr_last_d  = wr_last_q;
      cmd_d      = cmd_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      accum_d    = accum_q;
      remain_d   = remain_q;
      odd_d      = odd_q;
      cnt_d      = cnt_q;

      accept  = rx_data_valid_i && ready_q;
      timeout = !accept && (state_q != S_HDR0) && (state_q != S_WORD)
                && (cnt_q == CNT_MAX);

      if (accept || state_q == S_HDR0 || timeout) begin
         cnt_d = '0;
      end else if (state_q != S_WORD) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         S_HDR0: begin
            if (accept && rx_data_i == 8'h55) begin
               state_d = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               if (rx_data_i == 8'hAA) begin
                  state_d = S_CMD;
               end else if (rx_data_i != 8'h55) begin
                  state_d = S_HDR0;
               end
            end
         end
         S_CMD: begin
            if (accept) begin
               cmd_d   = rx_data_i;
               accum_d = rx_data_i;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (accept) begin
               remain_d = rx_data_i;
               accum_d  = accum_q + rx_data_i;
               odd_d    = 1'b0;
               state_d  = (rx_data_i == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               accum_d  = accum_q + rx_data_i;
               remain_d = remain_q - 8'd1;
               if (!odd_q) begin
                  wr_data_d[15:8] = rx_data_i;
                  if (remain_q == 8'd1) begin
                     // Odd-length frame: final byte goes out zero-padded.
                     wr_data_d[7:0] = 8'h00;
                     wr_last_d      = 1'b1;
                     state_d        = S_WORD;
                  end else begin
                     odd_d = 1'b1;
                  end
               end else begin
                  wr_data_d[7:0] = rx_data_i;
                  wr_last_d      = (remain_q == 8'd1);
                  odd_d          = 1'b0;
                  state_d        = S_WORD;
               end
            end
         end
         S_WORD: begin
            if (wr_ready_i) begin
               wr_last_d = 1'b0;
               state_d   = (remain_q == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (rx_data_i == accum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end
               state_d = S_HDR0;
            end
         end
         default: begin
            state_d = S_HDR0;
         end
      endcase

      if (timeout) begin
         state_d    = S_HDR0;
         err_d      = 1'b1;
         err_code_d = 2'b10;
      end

      // Ready is registered: it follows where the FSM is heading, so it is
      // already low in the first cycle a word is offered.
      ready_d = (state_d != S_WORD);
   end

   assign rx_data_ready_o = ready_q;
   assign wr_data_o       = wr_data_q;
   assign wr_valid_o      = (state_q == S_WORD);
   assign wr_last_o       = wr_last_q;
   assign cmd_o           = cmd_q;
   assign frame_done_o    = done_q;
   assign frame_err_o     = err_q;
   assign err_code_o      = err_code_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter CLK_FRE, default 50: clock frequency in MHz.
REQ-002 Parameter TIMEOUT_US, default 10000: inter-byte timeout in microseconds; TIMEOUT_CYC = CLK_FRE*TIMEOUT_US.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_data_valid  input  1  rx_data holds a byte; held until accepted.
REQ-007 rx_data_ready  output  1  parser accepts the byte this cycle.
REQ-008 wr_data  output  16  assembled payload word; first byte in [15:8].
REQ-009 wr_valid  output  1  wr_data valid.
REQ-010 wr_ready  input  1  downstream accepts the word.
REQ-011 wr_last  output  1  current word is the last of the frame.
REQ-012 cmd  output  8  command byte of the current/last frame.
REQ-013 frame_done  output  1  one-cycle pulse: frame complete, checksum good.
REQ-014 frame_err  output  1  one-cycle pulse: frame aborted.
REQ-015 err_code  output  2  01 checksum mismatch, 10 timeout; held until next frame_err.

Function
REQ-016 Frame format: 0x55, 0xAA, CMD, LEN (0..255 payload bytes), payload, CSUM; CSUM SHALL equal the 8-bit modulo sum of CMD, LEN and all payload bytes.
REQ-017 A byte SHALL be accepted only in a cycle where rx_data_valid and rx_data_ready are both 1.
REQ-018 States: S_HDR0, S_HDR1, S_CMD, S_LEN, S_PAYLOAD, S_WORD, S_CSUM.
REQ-019 S_HDR0: byte 0x55 -> S_HDR1; any other byte discarded.
REQ-020 S_HDR1: 0xAA -> S_CMD; 0x55 -> stay S_HDR1; other -> S_HDR0.
REQ-021 S_CMD: byte latched into cmd and checksum accumulator -> S_LEN.
REQ-022 S_LEN: byte latched as remaining count; LEN=0 -> S_CSUM, else -> S_PAYLOAD.
REQ-023 S_PAYLOAD: even-index byte -> wr_data[15:8]; odd-index byte -> wr_data[7:0], go S_WORD; if the even-index byte is the final byte (odd LEN), wr_data[7:0]=0x00 and go S_WORD.
REQ-024 S_WORD: wr_valid=1, wr_data stable; on wr_ready go S_PAYLOAD if bytes remain, else S_CSUM; wr_last=1 with the word containing the final payload byte.
REQ-025 rx_data_ready is registered: 1 in every state except S_WORD; 0 from the cycle wr_valid rises until the cycle after the word is accepted.
REQ-026 S_CSUM: byte equals accumulator -> frame_done pulse; else frame_err pulse, err_code=01; both -> S_HDR0.
REQ-027 Payload words SHALL be emitted before the checksum is checked; downstream discards on frame_err.
REQ-028 Timeout counter clears on every accepted byte and in S_HDR0, freezes in S_WORD, and counts in all other states.
REQ-029 Counter reaching TIMEOUT_CYC-1 -> frame_err pulse, err_code=10, return to S_HDR0.
REQ-030 frame_done and frame_err SHALL never be 1 in the same cycle.
REQ-031 Latency: frame_done/frame_err asserted the cycle after the CSUM byte is accepted.

Reset
REQ-032 While rst_n=0: state=S_HDR0; rx_data_ready, wr_valid, wr_last, frame_done and frame_err = 0; wr_data=0; cmd=0; err_code=00; accumulator and counters = 0.
REQ-033 Reset mid-frame discards the partial frame and any pending word with no frame_err; rx_data_ready=1 in the first cycle after release.

Verification
REQ-034 55 AA 01 04 12 34 56 78 19, wr_ready=1 -> words 0x1234, then 0x5678 with wr_last=1; frame_done pulse; cmd=0x01.
REQ-035 55 AA 02 03 AB CD EF 6C -> words 0xABCD, then 0xEF00 with wr_last=1; frame_done.
REQ-036 Frame from REQ-034 with CSUM=0x18 -> both words emitted, frame_err pulse, err_code=01, no frame_done.
REQ-037 55 55 AA 03 00 03 -> resync on the second 0x55; no words; frame_done; cmd=0x03.
REQ-038 wr_ready held 0 for 100 cycles at the first word -> wr_data stable, rx_data_ready=0, no timeout; frame completes normally on release.
REQ-039 55 AA 01 04 12, then idle TIMEOUT_CYC cycles -> frame_err, err_code=10, next 0x55 accepted in S_HDR0; separately, rst_n pulse mid-payload -> all outputs at reset values, no frame_err.
